// File: rtl/counter_mod_ud.sv
// Modulo-M up/down counter with clear, load, one-shot stop, compare match,
// a same-cycle terminal-count cascade output and a registered wrap pulse.
module counter_mod_ud #(
    parameter int M    = 60,
    parameter int INIT = 0,
    localparam int W   = $clog2(M)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         up,
    input  logic         oneshot,
    input  logic [W-1:0] cmp_val,
    output logic [W-1:0] counter,
    output logic         tc,
    output logic         carry,
    output logic         done,
    output logic         match
);

    localparam logic [W-1:0] MAX_V  = W'(M - 1);
    localparam logic [W-1:0] INIT_V = W'(INIT);

    logic         term;
    logic         step;
    logic [W-1:0] load_clamped;

    // Terminal value depends on the direction presented this cycle only.
    assign term         = up ? (counter == MAX_V) : (counter == '0);
    assign step         = en & ~clr & ~load & ~done;
    assign tc           = step & term;
    assign match        = (counter == cmp_val);
    assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter <= INIT_V;
            carry   <= 1'b0;
            done    <= 1'b0;
        end else if (clr) begin
            counter <= '0;
            carry   <= 1'b0;
            done    <= 1'b0;
        end else if (load) begin
            counter <= load_clamped;
            carry   <= 1'b0;
            done    <= 1'b0;
        end else begin
            // A wrap and a one-shot terminal step both pulse carry exactly once.
            carry <= tc;
            if (step) begin
                if (term) begin
                    if (oneshot) begin
                        done <= 1'b1;
                    end else begin
                        counter <= up ? '0 : MAX_V;
                    end
                end else begin
                    counter <= up ? (counter + W'(1)) : (counter - W'(1));
                end
            end
        end
    end

endmodule

// File: tb/tb_counter_mod_ud.sv
// Bench for counter_mod_ud: vector table, hand-written corner sequences and
// randomized traffic compared against a modular-arithmetic reference model.
module tb_counter_mod_ud;

    localparam int MA = 60;
    localparam int WA = 6;
    localparam int MB = 10;
    localparam int WB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // main instance, M=60
    logic          clr = 0, load = 0, en = 0, up = 1, oneshot = 0;
    logic [WA-1:0] load_val = '0, cmp_val = '0;
    logic [WA-1:0] counter;
    logic          tc, carry, done, match;

    counter_mod_ud #(.M(MA), .INIT(0)) dut (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up(up), .oneshot(oneshot), .cmp_val(cmp_val),
        .counter(counter), .tc(tc), .carry(carry), .done(done), .match(match)
    );

    // one-shot instance, M=10
    logic          b_clr = 0, b_load = 0, b_en = 0, b_up = 1, b_oneshot = 0;
    logic [WB-1:0] b_load_val = '0, b_cmp_val = '0;
    logic [WB-1:0] b_counter;
    logic          b_tc, b_carry, b_done, b_match;

    counter_mod_ud #(.M(MB), .INIT(0)) dut_b (
        .clk(clk), .rst(rst), .clr(b_clr), .load(b_load), .load_val(b_load_val),
        .en(b_en), .up(b_up), .oneshot(b_oneshot), .cmp_val(b_cmp_val),
        .counter(b_counter), .tc(b_tc), .carry(b_carry), .done(b_done), .match(b_match)
    );

    // cascade: seconds tc drives minutes en
    logic          c_load = 0, s_en = 0;
    logic [WA-1:0] c_load_val = '0;
    logic [WA-1:0] s_counter, n_counter;
    logic          s_tc, s_carry, s_done, s_match;
    logic          n_tc, n_carry, n_done, n_match;

    counter_mod_ud #(.M(MA), .INIT(0)) dut_sec (
        .clk(clk), .rst(rst), .clr(1'b0), .load(c_load), .load_val(c_load_val),
        .en(s_en), .up(1'b1), .oneshot(1'b0), .cmp_val(6'd0),
        .counter(s_counter), .tc(s_tc), .carry(s_carry), .done(s_done), .match(s_match)
    );

    counter_mod_ud #(.M(MA), .INIT(0)) dut_min (
        .clk(clk), .rst(rst), .clr(1'b0), .load(c_load), .load_val(c_load_val),
        .en(s_tc), .up(1'b1), .oneshot(1'b0), .cmp_val(6'd0),
        .counter(n_counter), .tc(n_tc), .carry(n_carry), .done(n_done), .match(n_match)
    );

    // reference model state for the main instance
    int m_cnt   = 0;
    int m_done  = 0;
    int m_carry = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int at_terminal();
        return up ? (m_cnt == MA - 1) : (m_cnt == 0);
    endfunction

    function automatic int model_tc();
        return (en && !clr && !load && (m_done == 0) && at_terminal()) ? 1 : 0;
    endfunction

    task automatic model_edge();
        if (clr) begin
            m_cnt = 0; m_done = 0; m_carry = 0;
        end else if (load) begin
            m_cnt = (int'(load_val) >= MA) ? MA - 1 : int'(load_val);
            m_done = 0; m_carry = 0;
        end else if (en && m_done == 0) begin
            m_carry = at_terminal();
            if (m_carry == 1 && oneshot) m_done = 1;
            else m_cnt = up ? (m_cnt + 1) % MA : (m_cnt + MA - 1) % MA;
        end else begin
            m_carry = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1 unit after an edge with inputs already driven.
    task automatic cyc();
        #4;
        chk("tc", tc, model_tc());
        chk("match", match, (m_cnt == int'(cmp_val)) ? 1 : 0);
        tick();
        model_edge();
        chk("counter", counter, m_cnt);
        chk("carry", carry, m_carry);
        chk("done", done, m_done);
    endtask

    task automatic idle_inputs();
        clr = 0; load = 0; en = 0; up = 1; oneshot = 0; load_val = '0; cmp_val = '0;
        b_clr = 0; b_load = 0; b_en = 0; b_up = 1; b_oneshot = 0;
        c_load = 0; s_en = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        #2;
        rst = 0;
        m_cnt = 0; m_done = 0; m_carry = 0;
        tick();
    endtask

    typedef struct {
        logic          clr, load;
        logic [WA-1:0] load_val;
        logic          en, up, oneshot;
        logic [WA-1:0] cmp_val;
        logic          exp_tc, exp_match;
        logic [WA-1:0] exp_cnt;
        logic          exp_carry, exp_done;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            clr load lv  en up os cmp  tc mt cnt cy dn
        vecs[0]  = '{0, 1, 58, 0, 1, 0, 0,  0, 1, 58, 0, 0};
        vecs[1]  = '{0, 0, 0,  1, 1, 0, 58, 0, 1, 59, 0, 0};
        vecs[2]  = '{0, 0, 0,  1, 1, 0, 59, 1, 1, 0,  1, 0};
        vecs[3]  = '{0, 0, 0,  1, 0, 0, 63, 1, 0, 59, 1, 0};
        vecs[4]  = '{0, 0, 0,  0, 0, 0, 59, 0, 1, 59, 0, 0};
        vecs[5]  = '{1, 1, 5,  1, 1, 0, 0,  0, 0, 0,  0, 0};
        vecs[6]  = '{0, 1, 63, 0, 1, 0, 60, 0, 0, 59, 0, 0};
        vecs[7]  = '{0, 0, 0,  1, 1, 1, 59, 1, 1, 59, 1, 1};
        vecs[8]  = '{0, 0, 0,  1, 1, 1, 0,  0, 0, 59, 0, 1};
        vecs[9]  = '{0, 0, 0,  1, 0, 0, 59, 0, 1, 59, 0, 1};
        vecs[10] = '{0, 1, 30, 1, 1, 0, 0,  0, 0, 30, 0, 0};
        vecs[11] = '{0, 0, 0,  0, 1, 0, 30, 0, 1, 30, 0, 0};

        // reset values
        idle_inputs();
        #13;
        chk("rst_counter", counter, 0);
        chk("rst_carry", carry, 0);
        chk("rst_done", done, 0);
        rst = 0;
        tick();

        // vector table
        do_reset();
        for (int i = 0; i < 12; i++) begin
            clr = vecs[i].clr; load = vecs[i].load; load_val = vecs[i].load_val;
            en = vecs[i].en; up = vecs[i].up; oneshot = vecs[i].oneshot;
            cmp_val = vecs[i].cmp_val;
            #4;
            chk($sformatf("vec%0d_tc", i), tc, vecs[i].exp_tc);
            chk($sformatf("vec%0d_match", i), match, vecs[i].exp_match);
            tick();
            chk($sformatf("vec%0d_counter", i), counter, vecs[i].exp_cnt);
            chk($sformatf("vec%0d_carry", i), carry, vecs[i].exp_carry);
            chk($sformatf("vec%0d_done", i), done, vecs[i].exp_done);
        end

        // full up-count with wrap; match on 30
        do_reset();
        en = 1; up = 1; cmp_val = 6'd30;
        for (int i = 0; i < 61; i++) begin
            #4;
            chk("up_tc", tc, (i % MA == MA - 1) ? 1 : 0);
            chk("up_match", match, (i % MA == 30) ? 1 : 0);
            tick();
            chk("up_counter", counter, (i + 1) % MA);
            chk("up_carry", carry, (i == MA - 1) ? 1 : 0);
            chk("up_done", done, 0);
        end

        // load 2, count down through the wrap
        do_reset();
        load = 1; load_val = 6'd2;
        cyc();
        load = 0; en = 1; up = 0;
        for (int i = 0; i < 3; i++) cyc();
        chk("down_wrap_counter", counter, 59);
        chk("down_wrap_carry", carry, 1);
        cyc();
        chk("down_after_counter", counter, 58);
        chk("down_after_carry", carry, 0);

        // one-shot on M=10
        do_reset();
        b_load = 1; b_load_val = 4'd7;
        tick();
        chk("os_load", b_counter, 7);
        b_load = 0; b_en = 1; b_up = 1; b_oneshot = 1;
        tick();
        chk("os_cnt8", b_counter, 8);
        #4;
        chk("os_tc_at9_pre", b_tc, 0);
        tick();
        chk("os_cnt9", b_counter, 9);
        #4;
        chk("os_tc_term", b_tc, 1);
        tick();
        chk("os_hold_cnt", b_counter, 9);
        chk("os_hold_done", b_done, 1);
        chk("os_hold_carry", b_carry, 1);
        for (int i = 0; i < 5; i++) begin
            #4;
            chk("os_frozen_tc", b_tc, 0);
            tick();
            chk("os_frozen_cnt", b_counter, 9);
            chk("os_frozen_carry", b_carry, 0);
            chk("os_frozen_done", b_done, 1);
        end
        b_oneshot = 0;
        tick();
        chk("os_mode_drop_done", b_done, 1);
        b_clr = 1;
        tick();
        chk("os_clr_cnt", b_counter, 0);
        chk("os_clr_done", b_done, 0);
        b_clr = 0; b_oneshot = 1;
        tick();
        chk("os_resume", b_counter, 1);

        // cascade sec -> min
        do_reset();
        c_load = 1; c_load_val = 6'd59;
        tick();
        c_load = 0; s_en = 1;
        #4;
        chk("cas_sec_tc", s_tc, 1);
        chk("cas_min_tc", n_tc, 1);
        tick();
        chk("cas_sec_cnt", s_counter, 0);
        chk("cas_min_cnt", n_counter, 0);
        chk("cas_sec_carry", s_carry, 1);
        chk("cas_min_carry", n_carry, 1);
        tick();
        chk("cas_sec_cnt2", s_counter, 1);
        chk("cas_min_cnt2", n_counter, 0);
        chk("cas_min_carry2", n_carry, 0);

        // asynchronous reset mid-cycle at 45
        do_reset();
        en = 1; up = 1;
        for (int i = 0; i < 45; i++) tick();
        en = 0;
        #1;
        chk("arst_pre", counter, 45);
        rst = 1;
        #1;
        chk("arst_counter", counter, 0);
        chk("arst_carry", carry, 0);
        chk("arst_done", done, 0);
        rst = 0;
        tick();

        // asynchronous reset while done is set
        do_reset();
        load = 1; load_val = 6'd59;
        tick();
        load = 0; en = 1; oneshot = 1;
        tick();
        chk("arst_done_set", done, 1);
        #1;
        rst = 1;
        #1;
        chk("arst_done_clear", done, 0);
        chk("arst_done_counter", counter, 0);
        chk("arst_done_carry", carry, 0);
        rst = 0;
        idle_inputs();
        tick();

        // randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            clr      = ($urandom_range(0, 59) == 0);
            load     = ($urandom_range(0, 19) == 0);
            load_val = WA'($urandom_range(0, 63));
            en       = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 29) == 0) up = ~up;
            if ($urandom_range(0, 39) == 0) oneshot = ~oneshot;
            cmp_val  = WA'($urandom_range(0, 63));
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
